jk_down_counter: RTL and testbench

- Synchronous down counter built from the team's JK flip-flop stages.
- Each stage's J/K inputs come from a per-bit 2:1 mux network that selects load, decrement toggle or hold.
- It is the decrementing counterpart of the existing JK up counter, for countdown timers and terminal-count detection.
- A parallel load, a count enable and a registered wrap/borrow flag are added.

---
 rtl/jk_down_counter_if.sv | 11 +
 rtl/jk_down_counter.sv | 40 ++++
 tb/tb_jk_down_counter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/jk_down_counter_if.sv
// jk_down_counter_if: control, load and status signals of the JK down counter
interface jk_down_counter_if #(parameter int WIDTH = 4);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             borrow;
    logic             zero;
    modport master (output en, load, load_val, input count, borrow, zero);
    modport slave  (input en, load, load_val, output count, borrow, zero);
endinterface

// File: rtl/jk_down_counter.sv
// jk_down_counter: WIDTH-stage JK down counter with parallel load, enable, borrow pulse and zero flag
module jk_down_counter #(parameter int WIDTH = 4) (
    input logic              clk,
    input logic              reset,
    jk_down_counter_if.slave bus
);
    logic [WIDTH-1:0] q_q, q_d, count_q, count_d, tog, j, k;
    logic             borrow_q, borrow_d, borrow_out_q, borrow_out_d;

    // Per-stage J/K mux on {load, en}: load drives J/K from load_val, en uses the borrow-ripple toggle chain, else hold
    always_comb begin
        tog[0] = 1'b1;
        for (int b = 1; b < WIDTH; b++) tog[b] = tog[b-1] & ~q_q[b-1];
        j = bus.load ? bus.load_val : (bus.en ? tog : '0);
        k = bus.load ? ~bus.load_val : (bus.en ? tog : '0);
        q_d = (j & ~q_q) | (~k & q_q);
        count_d = q_q;
        borrow_d = ~bus.load & bus.en & (q_q == '0);
        borrow_out_d = borrow_q;
    end

    // JK stages plus the one-cycle count and two-stage borrow pipelines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q          <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.borrow = borrow_out_q;
    assign bus.zero   = (count_q == '0);
endmodule

// File: tb/tb_jk_down_counter.sv
// tb_jk_down_counter: directed checks of the JK down counter at WIDTH 4 and 8
module tb_jk_down_counter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    jk_down_counter_if #(.WIDTH(4)) b4 ();
    jk_down_counter_if #(.WIDTH(8)) b8 ();

    jk_down_counter #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
    jk_down_counter #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic ld, input logic e, input logic [3:0] v);
        b4.load = ld;
        b4.en = e;
        b4.load_val = v;
    endtask

    task automatic chk4(input string name, input logic [3:0] c, input logic br, input logic z);
        checks++;
        if ({b4.count, b4.borrow, b4.zero} !== {c, br, z}) begin
            errors++;
            $display("FAIL %s: count=%0d borrow=%b zero=%b, expected count=%0d borrow=%b zero=%b",
                     name, b4.count, b4.borrow, b4.zero, c, br, z);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] c, input logic br, input logic z);
        checks++;
        if ({b8.count, b8.borrow, b8.zero} !== {c, br, z}) begin
            errors++;
            $display("FAIL %s: count=%0d borrow=%b zero=%b, expected count=%0d borrow=%b zero=%b",
                     name, b8.count, b8.borrow, b8.zero, c, br, z);
        end
    endtask

    task automatic test_reset();
        chk4("reset_initial", 4'd0, 1'b0, 1'b1);
        chk8("reset_initial_w8", 8'd0, 1'b0, 1'b1);
        drive4(1'b1, 1'b0, 4'd10);
        step();
        drive4(1'b0, 1'b1, 4'd0);
        step();
        chk4("pre_reset_count", 4'd10, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk4("reset_async", 4'd0, 1'b0, 1'b1);
        repeat (3) step();
        chk4("reset_held", 4'd0, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        chk4("release_edge1", 4'd0, 1'b0, 1'b1);
        step();
        chk4("release_edge2", 4'd15, 1'b1, 1'b0);
        step();
        chk4("release_edge3", 4'd14, 1'b0, 1'b0);
    endtask

    task automatic test_free_run();
        logic [3:0] exp;
        drive4(1'b1, 1'b0, 4'd0);
        step();
        drive4(1'b0, 1'b0, 4'd0);
        step();
        chk4("free_start", 4'd0, 1'b0, 1'b1);
        drive4(1'b0, 1'b1, 4'd0);
        for (int n = 1; n <= 18; n++) begin
            step();
            exp = 4'(17 - n);
            chk4($sformatf("free_edge%0d", n), exp, (n == 2) || (n == 18), exp == 4'd0);
        end
    endtask

    task automatic test_load_priority();
        drive4(1'b1, 1'b0, 4'd3);
        step();
        drive4(1'b1, 1'b1, 4'd10);
        step();
        chk4("prio_load_edge", 4'd3, 1'b0, 1'b0);
        drive4(1'b0, 1'b0, 4'd0);
        step();
        chk4("prio_count", 4'd10, 1'b0, 1'b0);
        step();
        chk4("prio_hold", 4'd10, 1'b0, 1'b0);
    endtask

    task automatic test_load_zero();
        drive4(1'b1, 1'b0, 4'd0);
        step();
        drive4(1'b1, 1'b1, 4'd15);
        step();
        chk4("lz_edge", 4'd0, 1'b0, 1'b1);
        drive4(1'b0, 1'b0, 4'd0);
        step();
        chk4("lz_count15", 4'd15, 1'b0, 1'b0);
        step();
        chk4("lz_no_borrow", 4'd15, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        logic       en_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_c  [5] = '{4'd6, 4'd5, 4'd5, 4'd5, 4'd4};
        drive4(1'b1, 1'b0, 4'd6);
        step();
        for (int n = 0; n < 5; n++) begin
            drive4(1'b0, (n < 4) ? en_seq[n] : 1'b0, 4'd0);
            step();
            chk4($sformatf("hold_step%0d", n), exp_c[n], 1'b0, 1'b0);
        end
    endtask

    task automatic test_wrap8();
        b8.load = 1'b1;
        b8.en = 1'b0;
        b8.load_val = 8'd1;
        step();
        b8.load = 1'b0;
        b8.en = 1'b1;
        step();
        chk8("w8_edge1", 8'd1, 1'b0, 1'b0);
        step();
        chk8("w8_edge2", 8'd0, 1'b0, 1'b1);
        b8.en = 1'b0;
        step();
        chk8("w8_wrap", 8'd255, 1'b1, 1'b0);
        step();
        chk8("w8_after", 8'd255, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        drive4(1'b0, 1'b0, 4'd0);
        b8.load = 1'b0;
        b8.en = 1'b0;
        b8.load_val = 8'd0;
        repeat (2) step();
        reset = 1'b0;
        test_reset();
        test_free_run();
        test_load_priority();
        test_load_zero();
        test_hold();
        test_wrap8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
